// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings, FSM state type and request checking for the
//               MEM-stage access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    typedef struct packed {
        logic misaligned;
        logic illegal;
    } req_status_t;

    function automatic req_status_t check_request(
        input logic [1:0] size,
        input logic [1:0] lane,
        input logic       is_read,
        input logic       is_write
    );
        req_status_t s;
        s.misaligned = ((size == SZ_HALF) && lane[0]) ||
                       ((size == SZ_WORD) && (lane != 2'b00));
        s.illegal    = (size == 2'b11) || (is_read && is_write);
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Little-endian lane extraction/extension for loads and lane
//               merge for sub-word stores (purely combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_is_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte        = i_rd_word[{i_lane, 3'b000} +: 8];
        w_half        = i_lane[1] ? i_rd_word[31:16] : i_rd_word[15:0];
        o_load_data   = i_rd_word;
        o_merged_word = i_rd_word;
        case (i_size)
            SZ_BYTE: begin
                o_load_data = {{24{~i_is_unsigned & w_byte[7]}}, w_byte};
                o_merged_word[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load_data = {{16{~i_is_unsigned & w_half[15]}}, w_half};
                o_merged_word[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage controller turning byte/half/word load-store
//               requests into word accesses on a combinational-read memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [ADDR_W-1:0] dm_address,
    output logic              dm_write_en,
    output logic [31:0]       dm_write_data,
    input  logic [31:0]       dm_read_data,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              wb_is_load,
    output logic              wb_err
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_rmw_addr;
    logic [31:0]       r_rmw_data;
    logic [TAG_W-1:0]  r_rmw_tag;

    logic [ADDR_W-1:0] w_word_addr;
    logic [1:0]        w_lane;
    req_status_t       w_status;
    logic              w_err;
    logic              w_accept;
    logic              w_word_store;
    logic              w_sub_store;
    logic              w_we;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    assign w_word_addr  = req_addr[ADDR_W+1:2];
    assign w_lane       = req_addr[1:0];
    assign w_status     = check_request(req_size, w_lane, req_read, req_write);
    assign w_err        = w_status.misaligned | w_status.illegal;
    assign req_ready    = (r_state == IDLE);
    assign w_accept     = req_valid & req_ready;
    assign w_word_store = req_write & ~w_err & (req_size == SZ_WORD);
    assign w_sub_store  = req_write & ~w_err & (req_size != SZ_WORD);
    // A write may never escape while reset is held, even with a request present.
    assign dm_write_en  = w_we & ~rst;

    mem_lane_align u_lane_align (
        .i_rd_word     (dm_read_data),
        .i_lane        (w_lane),
        .i_size        (req_size),
        .i_is_unsigned (req_unsigned),
        .i_wdata       (req_wdata),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        dm_address    = w_word_addr;
        dm_write_data = req_wdata;
        w_we          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_word_store) w_we = 1'b1;
                if (w_accept && w_sub_store)  w_next_state = RMW_WRITE;
            end
            RMW_WRITE: begin
                dm_address    = r_rmw_addr;
                dm_write_data = r_rmw_data;
                w_we          = 1'b1;
                w_next_state  = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_tag     <= '0;
            wb_is_load <= 1'b0;
            wb_err     <= 1'b0;
            r_rmw_addr <= '0;
            r_rmw_data <= '0;
            r_rmw_tag  <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (r_state == RMW_WRITE) begin
                wb_valid   <= 1'b1;
                wb_data    <= '0;
                wb_tag     <= r_rmw_tag;
                wb_is_load <= 1'b0;
                wb_err     <= 1'b0;
            end else if (w_accept) begin
                if (w_sub_store) begin
                    // Completion is reported from RMW_WRITE; wb fields hold meanwhile.
                    r_rmw_addr <= w_word_addr;
                    r_rmw_data <= w_merged;
                    r_rmw_tag  <= req_tag;
                end else begin
                    wb_valid   <= 1'b1;
                    wb_tag     <= req_tag;
                    wb_err     <= w_err;
                    wb_is_load <= req_read & ~req_write;
                    wb_data    <= (req_read && !w_err) ? w_load_data : 32'd0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit against a small
//               combinational-read word memory preloaded with ram[i] = i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int ADDR_W = 15;
    localparam int TAG_W  = 5;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_read;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic [ADDR_W-1:0] dm_address;
    logic              dm_write_en;
    logic [31:0]       dm_write_data;
    logic [31:0]       dm_read_data;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic [TAG_W-1:0]  wb_tag;
    logic              wb_is_load;
    logic              wb_err;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             is_load;
        logic             err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [31:0] ram [0:63];

    mem_access_unit #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_tag       (req_tag),
        .dm_address    (dm_address),
        .dm_write_en   (dm_write_en),
        .dm_write_data (dm_write_data),
        .dm_read_data  (dm_read_data),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_tag        (wb_tag),
        .wb_is_load    (wb_is_load),
        .wb_err        (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_read_data = ram[dm_address[5:0]];
    always @(posedge clk) if (dm_write_en) ram[dm_address[5:0]] <= dm_write_data;

    // Every completion pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wb_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL wb_unexpected: pulse with tag=%0d data=%h, nothing outstanding", wb_tag, wb_data);
            end else begin
                mon_e = sb.pop_front();
                if (wb_data !== mon_e.data || wb_tag !== mon_e.tag || wb_err !== mon_e.err ||
                    (!mon_e.err && wb_is_load !== mon_e.is_load)) begin
                    miscompares++;
                    $display("FAIL wb_result: got data=%h tag=%0d load=%b err=%b, expected data=%h tag=%0d load=%b err=%b",
                             wb_data, wb_tag, wb_is_load, wb_err, mon_e.data, mon_e.tag, mon_e.is_load, mon_e.err);
                end
            end
        end
    end

    task automatic idle_req();
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    // Called just after a falling edge; returns #1 later with the request on the bus.
    task automatic drive_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [ADDR_W+1:0] addr, input logic [31:0] wd, input logic [TAG_W-1:0] tag,
                             input logic expect_wb, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        int   n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        req_valid    = 1'b1;
        req_read     = rd;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_tag      = tag;
        if (expect_wb) begin
            e.data    = exp_data;
            e.tag     = tag;
            e.is_load = rd & ~wr;
            e.err     = exp_err;
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({wb_valid, wb_data, wb_tag, wb_is_load, wb_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_wb: valid=%b data=%h tag=%0d load=%b err=%b, required all 0",
                     wb_valid, wb_data, wb_tag, wb_is_load, wb_err);
        end
        vectors++;
        if (dm_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_we: dm_write_en=%b, required 0", dm_write_en);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_word_load();
        drive_req(1'b1, 1'b0, SZ_WORD, 1'b0, 17'h0008, 32'd0, 5'd7, 1'b1, 32'h0000_0002, 1'b0);
        vectors++;
        if (dm_address !== 15'd2 || dm_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL load_addr: dm_address=%0d we=%b, required 2 and 0", dm_address, dm_write_en);
        end
        @(negedge clk);
        idle_req();
        vectors++;
        if (wb_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL load_latency: wb_valid=%b one cycle after accept, required 1", wb_valid);
        end
    endtask

    task automatic test_byte_store();
        drive_req(1'b0, 1'b1, SZ_BYTE, 1'b0, 17'h000D, 32'h0000_00AB, 5'd3, 1'b1, 32'd0, 1'b0);
        vectors++;
        if (dm_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL byte_store_early: dm_write_en=%b in accept cycle, required 0", dm_write_en);
        end
        @(negedge clk);
        idle_req();
        #1;
        vectors++;
        if (req_ready !== 1'b0 || dm_address !== 15'd3 || dm_write_en !== 1'b1 || dm_write_data !== 32'h0000_AB03) begin
            miscompares++;
            $display("FAIL byte_rmw: ready=%b addr=%0d we=%b wdata=%h, required 0 3 1 0000ab03",
                     req_ready, dm_address, dm_write_en, dm_write_data);
        end
        drive_req(1'b1, 1'b0, SZ_BYTE, 1'b0, 17'h000D, 32'd0, 5'd4, 1'b1, 32'hFFFF_FFAB, 1'b0);
        @(negedge clk);
        idle_req();
        drive_req(1'b1, 1'b0, SZ_BYTE, 1'b1, 17'h000D, 32'd0, 5'd5, 1'b1, 32'h0000_00AB, 1'b0);
        @(negedge clk);
        idle_req();
    endtask

    task automatic test_half_store();
        drive_req(1'b0, 1'b1, SZ_HALF, 1'b0, 17'h0016, 32'h0000_1234, 5'd6, 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        idle_req();
        #1;
        vectors++;
        if (dm_address !== 15'd5 || dm_write_en !== 1'b1 || dm_write_data !== 32'h1234_0005) begin
            miscompares++;
            $display("FAIL half_rmw: addr=%0d we=%b wdata=%h, required 5 1 12340005",
                     dm_address, dm_write_en, dm_write_data);
        end
        drive_req(1'b1, 1'b0, SZ_HALF, 1'b0, 17'h0016, 32'd0, 5'd8, 1'b1, 32'h0000_1234, 1'b0);
        @(negedge clk);
        idle_req();
        drive_req(1'b0, 1'b1, SZ_HALF, 1'b0, 17'h0014, 32'h0000_8001, 5'd20, 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        idle_req();
        drive_req(1'b1, 1'b0, SZ_HALF, 1'b0, 17'h0014, 32'd0, 5'd21, 1'b1, 32'hFFFF_8001, 1'b0);
        @(negedge clk);
        idle_req();
        drive_req(1'b1, 1'b0, SZ_WORD, 1'b0, 17'h0014, 32'd0, 5'd22, 1'b1, 32'h1234_8001, 1'b0);
        @(negedge clk);
        idle_req();
    endtask

    task automatic test_errors();
        logic [3:0] we_seen;
        drive_req(1'b1, 1'b0, SZ_HALF, 1'b0, 17'h0011, 32'd0, 5'd9, 1'b1, 32'd0, 1'b1);
        we_seen[0] = dm_write_en;
        @(negedge clk);
        idle_req();
        drive_req(1'b0, 1'b1, SZ_WORD, 1'b0, 17'h0002, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'd0, 1'b1);
        we_seen[1] = dm_write_en;
        @(negedge clk);
        idle_req();
        drive_req(1'b0, 1'b1, 2'b11, 1'b0, 17'h0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'd0, 1'b1);
        we_seen[2] = dm_write_en;
        @(negedge clk);
        idle_req();
        drive_req(1'b1, 1'b1, SZ_WORD, 1'b0, 17'h0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'd0, 1'b1);
        we_seen[3] = dm_write_en;
        @(negedge clk);
        idle_req();
        vectors++;
        if (we_seen !== 4'b0000) begin
            miscompares++;
            $display("FAIL err_no_write: dm_write_en per error request=%b, required 0000", we_seen);
        end
        vectors++;
        if (ram[0] !== 32'd0 || ram[4] !== 32'd4) begin
            miscompares++;
            $display("FAIL err_mem: ram[0]=%h ram[4]=%h, required 0 and 4", ram[0], ram[4]);
        end
        drive_req(1'b0, 1'b0, SZ_WORD, 1'b0, 17'h0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'd0, 1'b0);
        vectors++;
        if (dm_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL nop_write: dm_write_en=%b, required 0", dm_write_en);
        end
        @(negedge clk);
        idle_req();
    endtask

    task automatic test_reset_mid_rmw();
        drive_req(1'b0, 1'b1, SZ_BYTE, 1'b0, 17'h0004, 32'h0000_0055, 5'd14, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        idle_req();
        rst = 1'b1;
        #1;
        vectors++;
        if (dm_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rmw_reset_we: dm_write_en=%b during reset, required 0", dm_write_en);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ram[1] !== 32'h0000_0001 || dm_write_en !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmw_reset_state: ram[1]=%h we=%b ready=%b, required 00000001 0 1",
                     ram[1], dm_write_en, req_ready);
        end
        vectors++;
        if ({wb_valid, wb_data, wb_tag, wb_is_load, wb_err} !== '0) begin
            miscompares++;
            $display("FAIL rmw_reset_wb: valid=%b data=%h tag=%0d load=%b err=%b, required all 0",
                     wb_valid, wb_data, wb_tag, wb_is_load, wb_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pulses;
        drive_req(1'b0, 1'b1, SZ_WORD, 1'b0, 17'h0020, 32'hDEAD_BEEF, 5'd15, 1'b1, 32'd0, 1'b0);
        vectors++;
        if (dm_write_en !== 1'b1 || dm_address !== 15'd8 || dm_write_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL b2b_store: we=%b addr=%0d wdata=%h, required 1 8 deadbeef",
                     dm_write_en, dm_address, dm_write_data);
        end
        @(negedge clk);
        pulses[0] = wb_valid;
        drive_req(1'b0, 1'b1, SZ_WORD, 1'b0, 17'h0020, 32'hDEAD_BEEF, 5'd16, 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        pulses[1] = wb_valid;
        drive_req(1'b1, 1'b0, SZ_WORD, 1'b0, 17'h0020, 32'd0, 5'd17, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        pulses[2] = wb_valid;
        idle_req();
        @(negedge clk);
        pulses[3] = wb_valid;
        vectors++;
        if (pulses !== 4'b0111) begin
            miscompares++;
            $display("FAIL b2b_pulses: wb_valid sequence (bit0 first)=%b, required 0111", pulses);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] <= i;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_tag      = '0;

        test_reset();
        test_word_load();
        test_byte_store();
        test_half_store();
        test_errors();
        test_reset_mid_rmw();
        test_back_to_back();

        for (int n = 0; n < 10 && sb.size() != 0; n++) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d completions never arrived, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
